// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the V/C requesters, the ssdram port and the arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
);
    logic              v_req_i;
    logic [ADDR_W-1:0] v_addr_i;
    logic              v_ack_o;
    logic [DATA_W-1:0] v_data_o;

    logic              c_req_i;
    logic              c_we_i;
    logic [ADDR_W-1:0] c_addr_i;
    logic [DATA_W-1:0] c_wdata_i;
    logic              c_ack_o;
    logic [DATA_W-1:0] c_rdata_o;

    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_data_o;
    logic [DATA_W-1:0] ram_data_i;
    logic              ram_cs_o;
    logic              ram_oe_o;
    logic              ram_we_o;
    logic              busy_o;

    modport slave (
        input  v_req_i, v_addr_i,
        input  c_req_i, c_we_i, c_addr_i, c_wdata_i,
        input  ram_data_i,
        output v_ack_o, v_data_o, c_ack_o, c_rdata_o,
        output ram_addr_o, ram_data_o, ram_cs_o, ram_oe_o, ram_we_o, busy_o
    );

    modport master (
        output v_req_i, v_addr_i,
        output c_req_i, c_we_i, c_addr_i, c_wdata_i,
        output ram_data_i,
        input  v_ack_o, v_data_o, c_ack_o, c_rdata_o,
        input  ram_addr_o, ram_data_o, ram_cs_o, ram_oe_o, ram_we_o, busy_o
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port (video V / CPU C) arbiter in front of the single ssdram port.
// Define SDRAM_ARB_RR_EN for strict round-robin instead of V priority + starvation guard.
module sdram_port_arbiter #(
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 6,
    parameter int STARVE_MAX    = 3
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    sdram_port_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam int             CNT_W    = $clog2(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sel_c_q, sel_c_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] v_data_q, v_data_d;
    logic [DATA_W-1:0] c_data_q, c_data_d;
    logic              v_ack_q, v_ack_d;
    logic              c_ack_q, c_ack_d;
    logic              grant_v, grant_c;

`ifdef SDRAM_ARB_RR_EN
    logic last_c_q, last_c_d;

    // On contention the port that was not granted last wins.
    always_comb begin
        grant_c = bus.c_req_i && (!bus.v_req_i || !last_c_q);
        grant_v = bus.v_req_i && (!bus.c_req_i || last_c_q);
    end
`else
    localparam int            STV_W     = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);

    logic [STV_W-1:0] starve_q, starve_d;

    always_comb begin
        grant_c = bus.c_req_i && ((starve_q == STARVE_LIM) || !bus.v_req_i);
        grant_v = bus.v_req_i && !grant_c;
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_c_d  = sel_c_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        v_data_d = v_data_q;
        c_data_d = c_data_q;
        v_ack_d  = 1'b0;
        c_ack_d  = 1'b0;
`ifdef SDRAM_ARB_RR_EN
        last_c_d = last_c_q;
`else
        starve_d = starve_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_v || grant_c) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                    sel_c_d = grant_c;
                    if (grant_c) begin
                        we_d    = bus.c_we_i;
                        addr_d  = bus.c_addr_i;
                        wdata_d = bus.c_wdata_i;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = bus.v_addr_i;
                    end
                end
`ifdef SDRAM_ARB_RR_EN
                if (grant_v || grant_c) begin
                    last_c_d = grant_c;
                end
`else
                if (!bus.c_req_i || grant_c) begin
                    starve_d = '0;
                end else if (grant_v && (starve_q != STARVE_LIM)) begin
                    starve_d = starve_q + 1'b1;
                end
`endif
            end
            S_ACCESS: begin
                // Read data is captured on the final clock of the cs window.
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    if (sel_c_q) begin
                        c_ack_d = 1'b1;
                        if (!we_q) begin
                            c_data_d = bus.ram_data_i;
                        end
                    end else begin
                        v_ack_d  = 1'b1;
                        v_data_d = bus.ram_data_i;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sel_c_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            v_data_q <= '0;
            c_data_q <= '0;
            v_ack_q  <= 1'b0;
            c_ack_q  <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            last_c_q <= 1'b0;
`else
            starve_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_c_q  <= sel_c_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            v_data_q <= v_data_d;
            c_data_q <= c_data_d;
            v_ack_q  <= v_ack_d;
            c_ack_q  <= c_ack_d;
`ifdef SDRAM_ARB_RR_EN
            last_c_q <= last_c_d;
`else
            starve_q <= starve_d;
`endif
        end
    end

    // Strobes decode from registered state only; no path from req inputs.
    assign bus.ram_cs_o   = (state_q == S_ACCESS);
    assign bus.ram_oe_o   = (state_q == S_ACCESS) && !we_q;
    assign bus.ram_we_o   = (state_q == S_ACCESS) && we_q;
    assign bus.ram_addr_o = addr_q;
    assign bus.ram_data_o = wdata_q;
    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.v_ack_o    = v_ack_q;
    assign bus.v_data_o   = v_data_q;
    assign bus.c_ack_o    = c_ack_q;
    assign bus.c_rdata_o  = c_data_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: vector table of single accesses, contention,
// starvation and reset sequences, then a randomized run against a memory model.
module tb_sdram_port_arbiter;
    localparam int AW = 18;
    localparam int DW = 8;
    localparam int AC = 6;
    localparam int SM = 3;
    localparam int NRAND = 100;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

    sdram_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC), .STARVE_MAX(SM)
    ) dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .bus       (ifc.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic last_c;

    // ssdram stand-in: either a byte memory or a bench-driven read value
    logic [DW-1:0] mem [0:255];
    logic          ram_model_en;
    logic          mem_clr;
    logic [DW-1:0] manual_rdata;
    assign ifc.ram_data_i = ram_model_en ? mem[ifc.ram_addr_o[7:0]] : manual_rdata;

    function automatic logic [7:0] hash(input int a);
        return 8'((a * 37 + 11) ^ (a >> 3));
    endfunction

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int a = 0; a < 256; a++) mem[a] <= hash(a);
        end else if (ifc.ram_cs_o && ifc.ram_we_o) begin
            mem[ifc.ram_addr_o[7:0]] <= ifc.ram_data_o;
        end
    end

    // cs window monitor: run lengths and addr/data stability inside a window
    int            cs_run, cs_min, cs_max;
    logic          win_bad, mon_clr;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;
    always @(negedge clk) begin
        if (mon_clr) begin
            cs_run = 0; cs_min = 1000; cs_max = 0; win_bad = 1'b0;
        end else if (ifc.ram_cs_o) begin
            if (cs_run == 0) begin
                win_addr = ifc.ram_addr_o;
                win_data = ifc.ram_data_o;
            end else if (ifc.ram_addr_o != win_addr || ifc.ram_data_o != win_data) begin
                win_bad = 1'b1;
            end
            cs_run++;
        end else if (cs_run != 0) begin
            if (cs_run < cs_min) cs_min = cs_run;
            if (cs_run > cs_max) cs_max = cs_run;
            cs_run = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    typedef struct {
        logic          is_c;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;     // value memory presents on the last access clock
        logic          exp_oe;
        logic          exp_we;
        logic [DW-1:0] exp_data;  // winner's data output at its ack
    } vec_t;

    vec_t vecs [6];

    // Called at a negedge in IDLE; the following posedge grants.
    task automatic run_vec(input int idx, input vec_t v);
        logic exp_cs;
        if (v.is_c) begin
            ifc.c_req_i = 1'b1; ifc.c_we_i = v.we;
            ifc.c_addr_i = v.addr; ifc.c_wdata_i = v.wdata;
        end else begin
            ifc.v_req_i = 1'b1; ifc.v_addr_i = v.addr;
        end
        manual_rdata = ~v.rdata;
        for (int k = 0; k <= AC + 1; k++) begin
            tick();
            manual_rdata = (k == AC - 1) ? v.rdata : ~v.rdata;
            exp_cs = (k < AC);
            check($sformatf("vec%0d_cs_k%0d", idx, k), ifc.ram_cs_o, exp_cs);
            check($sformatf("vec%0d_oe_k%0d", idx, k), ifc.ram_oe_o, exp_cs & v.exp_oe);
            check($sformatf("vec%0d_we_k%0d", idx, k), ifc.ram_we_o, exp_cs & v.exp_we);
            if (exp_cs) begin
                check($sformatf("vec%0d_addr_k%0d", idx, k), ifc.ram_addr_o, v.addr);
                if (v.we) check($sformatf("vec%0d_wdata_k%0d", idx, k), ifc.ram_data_o, v.wdata);
            end
            check($sformatf("vec%0d_vack_k%0d", idx, k), ifc.v_ack_o, !v.is_c && k == AC);
            check($sformatf("vec%0d_cack_k%0d", idx, k), ifc.c_ack_o, v.is_c && k == AC);
            check($sformatf("vec%0d_busy_k%0d", idx, k), ifc.busy_o, k <= AC);
            if (k == AC) begin
                if (v.is_c) check($sformatf("vec%0d_crdata", idx), ifc.c_rdata_o, v.exp_data);
                else        check($sformatf("vec%0d_vdata", idx), ifc.v_data_o, v.exp_data);
                ifc.v_req_i = 1'b0;
                ifc.c_req_i = 1'b0;
                last_c = v.is_c;
            end
        end
    endtask

    task automatic test_simultaneous();
        logic first_c;
        int tv, tc;
`ifdef SDRAM_ARB_RR_EN
        first_c = !last_c;
`else
        first_c = 1'b0;
`endif
        tv = -1; tc = -1;
        tick();
        manual_rdata = 8'h42;
        ifc.v_addr_i = 18'h01000; ifc.c_addr_i = 18'h02000; ifc.c_we_i = 1'b0;
        ifc.v_req_i = 1'b1; ifc.c_req_i = 1'b1;
        for (int cyc = 0; cyc < 4 * (AC + 2); cyc++) begin
            tick();
            if (ifc.v_ack_o) begin tv = cyc; ifc.v_req_i = 1'b0; end
            if (ifc.c_ack_o) begin tc = cyc; ifc.c_req_i = 1'b0; end
        end
        check("both_v_ack_cycle", tv, first_c ? 2 * AC + 2 : AC);
        check("both_c_ack_cycle", tc, first_c ? AC : 2 * AC + 2);
        check("both_v_data", ifc.v_data_o, 8'h42);
        check("both_c_data", ifc.c_rdata_o, 8'h42);
        last_c = !first_c;
    endtask

    task automatic test_starve();
        int   n;
        logic ord [8];
        int   at  [8];
        logic first_c;
        logic exp_c;
        n = 0;
        first_c = !last_c;
        tick(); tick();
        manual_rdata = 8'h17;
        ifc.c_we_i = 1'b0; ifc.c_addr_i = 18'h00300; ifc.v_addr_i = 18'h00400;
        ifc.v_req_i = 1'b1; ifc.c_req_i = 1'b1;
        for (int cyc = 0; cyc < 12 * (AC + 2) && n < 8; cyc++) begin
            tick();
            if (ifc.v_ack_o && n < 8) begin ord[n] = 1'b0; at[n] = cyc; n++; end
            if (ifc.c_ack_o && n < 8) begin ord[n] = 1'b1; at[n] = cyc; n++; end
        end
        ifc.v_req_i = 1'b0; ifc.c_req_i = 1'b0;
        check("starve_ack_count", n, 8);
        for (int i = 0; i < n; i++) begin
`ifdef SDRAM_ARB_RR_EN
            exp_c = first_c ^ i[0];
`else
            exp_c = (i % (SM + 1)) == SM;
`endif
            check($sformatf("starve_order_%0d", i), ord[i], exp_c);
            check($sformatf("starve_time_%0d", i), at[i], AC + i * (AC + 2));
        end
        if (n > 0) last_c = ord[n-1];
        tick();
    endtask

    task automatic test_reset_mid_read();
        tick();
        manual_rdata = 8'h99;
        ifc.c_we_i = 1'b0; ifc.c_addr_i = 18'h00777; ifc.c_req_i = 1'b1;
        tick(); tick(); tick();
        check("rst_pre_cs", ifc.ram_cs_o, 1'b1);
        check("rst_pre_oe", ifc.ram_oe_o, 1'b1);
        rst_n = 1'b0;
        ifc.c_req_i = 1'b0;
        tick();
        check("rst_cs_drop", ifc.ram_cs_o, 1'b0);
        check("rst_oe_drop", ifc.ram_oe_o, 1'b0);
        check("rst_busy", ifc.busy_o, 1'b0);
        check("rst_no_cack", ifc.c_ack_o, 1'b0);
        tick();
        check("rst_crdata", ifc.c_rdata_o, 8'h00);
        check("rst_vdata", ifc.v_data_o, 8'h00);
        rst_n = 1'b1;
        last_c = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rst_after_cack_%0d", k), ifc.c_ack_o, 1'b0);
            check($sformatf("rst_after_busy_%0d", k), ifc.busy_o, 1'b0);
        end
        run_vec(6, vecs[1]);
    endtask

    logic [7:0] ref_mem [int];

    function automatic logic [7:0] ref_rd(input logic [7:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return hash(int'(a));
    endfunction

    task automatic test_random();
        int   issued, v_iss, c_iss, v_got, c_got;
        logic vp, cp, cwe;
        logic [7:0] va, ca, cwd;
        issued = 0; v_iss = 0; c_iss = 0; v_got = 0; c_got = 0;
        vp = 1'b0; cp = 1'b0; cwe = 1'b0; va = '0; ca = '0; cwd = '0;
        mon_clr = 1'b1; tick(); tick(); mon_clr = 1'b0;
        ram_model_en = 1'b1;
        for (int cyc = 0; cyc < 20000 && !(issued >= NRAND && !vp && !cp); cyc++) begin
            tick();
            if (ifc.v_ack_o) begin
                check("rand_v_ack_had_req", vp, 1'b1);
                check("rand_v_data", ifc.v_data_o, ref_rd(va));
                vp = 1'b0; ifc.v_req_i = 1'b0; v_got++;
            end
            if (ifc.c_ack_o) begin
                check("rand_c_ack_had_req", cp, 1'b1);
                if (cwe) ref_mem[int'(ca)] = cwd;
                else     check("rand_c_rdata", ifc.c_rdata_o, ref_rd(ca));
                cp = 1'b0; ifc.c_req_i = 1'b0; c_got++;
            end
            if (!vp && issued < NRAND && $urandom_range(3) == 0) begin
                ifc.v_addr_i = AW'($urandom);
                va = ifc.v_addr_i[7:0];
                ifc.v_req_i = 1'b1; vp = 1'b1; issued++; v_iss++;
            end
            if (!cp && issued < NRAND && $urandom_range(2) == 0) begin
                ifc.c_addr_i  = AW'($urandom);
                ifc.c_we_i    = 1'(($urandom) & 1);
                ifc.c_wdata_i = DW'($urandom);
                ca = ifc.c_addr_i[7:0]; cwe = ifc.c_we_i; cwd = ifc.c_wdata_i;
                ifc.c_req_i = 1'b1; cp = 1'b1; issued++; c_iss++;
            end
        end
        check("rand_all_done", (issued == NRAND) && !vp && !cp, 1'b1);
        check("rand_v_ack_count", v_got, v_iss);
        check("rand_c_ack_count", c_got, c_iss);
        tick(); tick();
        check("rand_cs_run_max", cs_max, AC);
        check("rand_cs_run_min", cs_min, AC);
        check("rand_window_stable", win_bad, 1'b0);
        ram_model_en = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 18'h00123, 8'hA5, 8'h77, 1'b0, 1'b1, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 18'h00040, 8'h00, 8'h3C, 1'b1, 1'b0, 8'h3C};
        vecs[2] = '{1'b0, 1'b0, 18'h3FFFF, 8'h00, 8'h5A, 1'b1, 1'b0, 8'h5A};
        vecs[3] = '{1'b1, 1'b1, 18'h2AAAA, 8'hFF, 8'h11, 1'b0, 1'b1, 8'h3C};
        vecs[4] = '{1'b0, 1'b0, 18'h00000, 8'h00, 8'hC3, 1'b1, 1'b0, 8'hC3};
        vecs[5] = '{1'b1, 1'b0, 18'h15555, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00};

        rst_n = 1'b0; mem_clr = 1'b1; mon_clr = 1'b1;
        ram_model_en = 1'b0; manual_rdata = '0; last_c = 1'b0;
        ifc.v_req_i = 1'b0; ifc.v_addr_i = '0;
        ifc.c_req_i = 1'b0; ifc.c_we_i = 1'b0; ifc.c_addr_i = '0; ifc.c_wdata_i = '0;
        repeat (3) tick();

        check("reset_v_ack", ifc.v_ack_o, 1'b0);
        check("reset_c_ack", ifc.c_ack_o, 1'b0);
        check("reset_cs", ifc.ram_cs_o, 1'b0);
        check("reset_oe", ifc.ram_oe_o, 1'b0);
        check("reset_we", ifc.ram_we_o, 1'b0);
        check("reset_busy", ifc.busy_o, 1'b0);
        check("reset_addr", ifc.ram_addr_o, '0);
        check("reset_wdata", ifc.ram_data_o, '0);
        check("reset_v_data", ifc.v_data_o, '0);
        check("reset_c_rdata", ifc.c_rdata_o, '0);

        rst_n = 1'b1; mem_clr = 1'b0; mon_clr = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
        test_simultaneous();
        test_starve();
        test_reset_mid_read();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end
endmodule
